irq_arbiter: RTL and testbench

//  Multi-source interrupt front end for the pipelined core. Synchronises N

---
 rtl/irq_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_irq_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter
//   Multi-source interrupt front end for the pipelined core. Each raw source
//   line is synchronised and edge-detected. Rising edges latch into a pending
//   vector. A round-robin pick among the enabled pending sources drives the
//   csr block's single interrupt request. The request is held until the core
//   takes it. The arbiter then waits for the ISR return before it issues the
//   next request.
//
// Ports
//   clk          core clock
//   rst          asynchronous, active-high reset
//   src_in       raw asynchronous interrupt lines (rising-edge events)
//   mask_we      load mask_wdata into the mask register
//   mask_wdata   new mask value, 1 = source enabled
//   irq_taken    1-cycle pulse, core redirected the PC to the ISR
//   irq_ret      1-cycle pulse, core returned from the ISR
//   irq          interrupt request to csr
//   cause_valid  cause_id holds the source currently being serviced
//   cause_id     index of the granted source
//   pending      latched events not yet serviced (masked sources included)
//   busy         arbiter is not idle

module irq_arbiter #(
  parameter int N_SRC       = 8,
  parameter int IDW         = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             irq_taken,
  input  logic             irq_ret,
  output logic             irq,
  output logic             cause_valid,
  output logic [IDW-1:0]   cause_id,
  output logic [N_SRC-1:0] pending,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_T = 16'(TIMEOUT);

  state_t                             state;
  logic [SYNC_STAGES-1:0][N_SRC-1:0]  sync_q;
  logic [N_SRC-1:0]                   src_prev;
  logic [N_SRC-1:0]                   src_event;
  logic [N_SRC-1:0]                   mask;
  logic [N_SRC-1:0]                   eligible;
  logic [N_SRC-1:0]                   clear_vec;
  logic [IDW-1:0]                     rr_ptr;
  logic [IDW-1:0]                     rr_next;
  logic [IDW-1:0]                     winner;
  logic [15:0]                        timer;

  // The synchroniser and edge registers reset to 0. A line that is already
  // high when reset is released therefore produces exactly one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      src_prev <= '0;
    end else begin
      sync_q[0] <= src_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      src_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign src_event = sync_q[SYNC_STAGES-1] & ~src_prev;

  // Clear the serviced source on the cycle the ISR returns.
  always_comb begin
    clear_vec = '0;
    if (state == SERVICE && irq_ret) begin
      clear_vec[cause_id] = 1'b1;
    end
  end

  // A new event is OR'd in after the clear. If an edge arrives on the clear
  // cycle, the set wins and the source stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clear_vec) | src_event;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '1;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  assign eligible = pending & mask;

  // Round robin: take the first eligible index, scanning upward from rr_ptr
  // and wrapping from N_SRC-1 back to 0.
  always_comb begin
    int             idx;
    logic           found;
    logic [IDW-1:0] idx_w;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_SRC) begin
        idx = idx - N_SRC;
      end
      idx_w = IDW'(idx);
      if (!found && eligible[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  assign rr_next = (cause_id == IDW'(N_SRC - 1)) ? '0 : cause_id + IDW'(1);

  // Request FSM. The outputs are registered alongside the state.
  // The timer limits how long an untaken request may stay asserted. When it
  // expires, the FSM drops back to IDLE with pending untouched, so the source
  // is re-arbitrated after one idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      irq         <= 1'b0;
      cause_valid <= 1'b0;
      cause_id    <= '0;
      timer       <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            state       <= ASSERT;
            cause_id    <= winner;
            irq         <= 1'b1;
            cause_valid <= 1'b1;
            timer       <= '0;
          end
        end
        ASSERT: begin
          if (irq_taken) begin
            state <= SERVICE;
            irq   <= 1'b0;
          end else if (timer == TIMEOUT_T) begin
            state       <= IDLE;
            irq         <= 1'b0;
            cause_valid <= 1'b0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        SERVICE: begin
          if (irq_ret) begin
            state       <= IDLE;
            cause_valid <= 1'b0;
            rr_ptr      <= rr_next;
          end
        end
        default: begin
          state       <= IDLE;
          irq         <= 1'b0;
          cause_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter
//   Directed bench for irq_arbiter with TIMEOUT shortened to 4. Inputs are
//   driven and outputs are sampled on the falling clock edge. Expected values
//   are hand-derived from the sync latency (SYNC_STAGES+1 edges to pending),
//   the one-cycle grant delay, and the round-robin order.

module tb_irq_arbiter;

  localparam int N_SRC = 8;
  localparam int IDW   = 3;

  logic             clk;
  logic             rst;
  logic [N_SRC-1:0] src_in;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             irq_taken;
  logic             irq_ret;
  logic             irq;
  logic             cause_valid;
  logic [IDW-1:0]   cause_id;
  logic [N_SRC-1:0] pending;
  logic             busy;

  int checks = 0;
  int passes = 0;

  irq_arbiter #(
    .N_SRC(N_SRC), .IDW(IDW), .SYNC_STAGES(2), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .src_in(src_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .irq_taken(irq_taken), .irq_ret(irq_ret),
    .irq(irq), .cause_valid(cause_valid), .cause_id(cause_id),
    .pending(pending), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stops a stuck run, but still reports it.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the core handshake pulses for exactly one cycle.
  task automatic applyStimulus(input logic taken, input logic ret);
    irq_taken = taken;
    irq_ret   = ret;
    @(negedge clk);
    irq_taken = 1'b0;
    irq_ret   = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // The sources are high for one cycle. Pending appears two negedges after
  // the task returns.
  task automatic pulseSrc(input logic [N_SRC-1:0] bits);
    src_in = bits;
    @(negedge clk);
    src_in = '0;
  endtask

  task automatic writeMask(input logic [N_SRC-1:0] value);
    mask_we    = 1'b1;
    mask_wdata = value;
    @(negedge clk);
    mask_we    = 1'b0;
  endtask

  // Expects an active request for id, then takes it and returns from it.
  task automatic serviceGrant(input logic [IDW-1:0] id);
    checkOutput("grant_irq", 32'(irq), 32'd1);
    checkOutput("grant_id", 32'(cause_id), 32'(id));
    checkOutput("grant_valid", 32'(cause_valid), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("taken_irq", 32'(irq), 32'd0);
    checkOutput("taken_busy", 32'(busy), 32'd1);
    checkOutput("taken_valid", 32'(cause_valid), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ret_busy", 32'(busy), 32'd0);
    checkOutput("ret_valid", 32'(cause_valid), 32'd0);
    checkOutput("ret_pending_bit", 32'(pending[id]), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    src_in     = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    irq_taken  = 1'b0;
    irq_ret    = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);

    // Reset state.
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_valid", 32'(cause_valid), 32'd0);
    checkOutput("rst_id", 32'(cause_id), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Single source. The line is held high and must produce only one grant.
    src_in = 8'h08;
    step(2);
    checkOutput("single_early", 32'(pending), 32'h00);
    step(1);
    checkOutput("single_pending", 32'(pending), 32'h08);
    checkOutput("single_irq_lag", 32'(irq), 32'd0);
    step(1);
    serviceGrant(3'd3);
    step(6);
    checkOutput("single_no_regrant", 32'(irq), 32'd0);
    checkOutput("single_pending_clr", 32'(pending), 32'h00);
    checkOutput("single_idle", 32'(busy), 32'd0);
    src_in = '0;
    step(3);

    // A spurious irq_taken while idle is ignored.
    applyStimulus(1'b1, 1'b0);
    checkOutput("spur_taken_busy", 32'(busy), 32'd0);
    checkOutput("spur_taken_irq", 32'(irq), 32'd0);

    // Round robin from rr_ptr=0, then from rr_ptr=6.
    applyReset();
    pulseSrc(8'h25);
    step(2);
    checkOutput("rr_pending", 32'(pending), 32'h25);
    step(1);
    serviceGrant(3'd0);
    step(1);
    serviceGrant(3'd2);
    step(1);
    serviceGrant(3'd5);
    checkOutput("rr_drained", 32'(pending), 32'h00);
    pulseSrc(8'h21);
    step(3);
    serviceGrant(3'd0);
    step(1);
    serviceGrant(3'd5);

    // Mask: a masked source latches pending but is not granted until it is
    // unmasked.
    writeMask(8'hFB);
    pulseSrc(8'h04);
    step(2);
    checkOutput("mask_pending", 32'(pending), 32'h04);
    step(2);
    checkOutput("mask_irq_low", 32'(irq), 32'd0);
    checkOutput("mask_busy_low", 32'(busy), 32'd0);
    mask_we    = 1'b1;
    mask_wdata = 8'hFF;
    step(1);
    mask_we = 1'b0;
    checkOutput("unmask_lag", 32'(irq), 32'd0);
    step(1);
    serviceGrant(3'd2);

    // Timeout: irq stays high for timer values 0..4, drops for one cycle,
    // then reasserts.
    pulseSrc(8'h02);
    step(3);
    for (int c = 0; c < 5; c++) begin
      checkOutput("timeout_irq_high", 32'(irq), 32'd1);
      step(1);
    end
    checkOutput("timeout_irq_drop", 32'(irq), 32'd0);
    checkOutput("timeout_valid_drop", 32'(cause_valid), 32'd0);
    checkOutput("timeout_pending_kept", 32'(pending), 32'h02);
    step(1);
    serviceGrant(3'd1);

    // Races: a spurious ret in ASSERT, then a new edge on the clear cycle.
    pulseSrc(8'h08);
    step(3);
    checkOutput("race_grant_id", 32'(cause_id), 32'd3);
    applyStimulus(1'b0, 1'b1);
    checkOutput("race_spur_ret_irq", 32'(irq), 32'd1);
    checkOutput("race_spur_ret_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("race_service_irq", 32'(irq), 32'd0);
    pulseSrc(8'h08);
    step(1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("race_set_wins", 32'(pending), 32'h08);
    checkOutput("race_idle", 32'(busy), 32'd0);
    step(1);
    serviceGrant(3'd3);

    // An asynchronous reset mid-ASSERT clears the outputs immediately, and
    // the mask returns to all ones.
    writeMask(8'h7F);
    pulseSrc(8'h10);
    step(2);
    checkOutput("arst_pre_pending", 32'(pending), 32'h10);
    step(1);
    checkOutput("arst_pre_irq", 32'(irq), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("arst_irq", 32'(irq), 32'd0);
    checkOutput("arst_valid", 32'(cause_valid), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_pending", 32'(pending), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    pulseSrc(8'h80);
    step(2);
    checkOutput("arst_mask_pending", 32'(pending), 32'h80);
    step(1);
    serviceGrant(3'd7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
